dcp_tx_printer: RTL and testbench
=================================

// Module: dcp_tx_printer
// PURPOSE
//   Serves the transmit request port of the debug-unit command handlers (req_tx/type_tx/dout -> ack_tx).
//   Formats each request as ASCII bytes and streams them to the UART byte transmitter over valid/ready.
//   Pulses ack_tx once per request, after the final byte has been accepted.
//   Sits between the command-handler TX mux and the UART TX byte engine.
// PARAMETERS
//   UPPER_CASE  1  1: hex digits A-F sent as 0x41-0x46; 0: sent as 0x61-0x66
//   HEX_SPACE   1  1: a type-1 word is followed by one 0x20 byte; 0: no trailing byte
// PORTS
//   clk      in   1   system clock, all state on rising edge
//   rst      in   1   asynchronous, active-high reset
//   req_tx   in   1   request from the command handler; held high until ack_tx is seen
//   type_tx  in   1   0: send din_tx[7:0] as one raw byte; 1: send din_tx as 8 hex digits
//   din_tx   in   32  payload; valid while req_tx is high
//   ack_tx   out  1   one-cycle pulse: request fully transmitted
//   tx_data  out  8   byte to the UART transmitter
//   tx_vld   out  1   tx_data valid
//   tx_rdy   in   1   UART transmitter accepts tx_data this cycle
//   busy     out  1   high in every state except IDLE
// BEHAVIOUR
//   Reset: ack_tx=0, tx_vld=0, tx_data=8'h00, busy=0, FSM=IDLE, latched word/type/index cleared.
//     rst asserted mid-transfer aborts the transfer at once: no further bytes, no ack.
//   Byte transfer: occurs on a cycle with tx_vld&&tx_rdy. While tx_vld=1 and tx_rdy=0, tx_data is held stable.
//   FSM:
//     IDLE : if req_tx=1, latch din_tx, type_tx; idx<=0; last<= type?(HEX_SPACE?8:7):0; -> SEND.
//     SEND : tx_vld=1; tx_data=byte(idx). On tx_rdy: if idx==last -> ACK, else idx<=idx+1.
//     ACK  : ack_tx=1 for exactly this cycle; tx_vld=0; -> WAITLO.
//     WAITLO: ignore req_tx until it is sampled 0, then -> IDLE. This prevents the still-high
//            registered req of the same request from starting a duplicate transfer.
//   Byte select: type 0 -> word[7:0] (raw, no conversion). Type 1 -> idx 0..7 = nibble
//     word[31-4*idx -: 4], MSB first. Nibble n<10 -> 8'h30+n; else 8'h41+n-10 (UC) / 8'h61+n-10.
//     idx 8 (HEX_SPACE only) -> 8'h20. idx is 4 bits.
//   Latency: req_tx sampled high at edge k -> tx_vld=1 from cycle k+1. Final byte accepted at edge m
//     -> ack_tx=1 during cycle m+1. With tx_rdy tied 1, type 0 takes 3 cycles and type 1 takes
//     11 cycles (HEX_SPACE=1) from IDLE to the return to IDLE, assuming req_tx drops right after ack.
//   Payload/type are sampled only in IDLE. Later changes to din_tx/type_tx, including the handler's
//     own state change, do not affect the bytes in flight.
//   req_tx falling during SEND (protocol violation): the transfer still completes and ack_tx still pulses.
//   ack_tx is never high for two consecutive cycles. Back-to-back requests need one req_tx=0 cycle between them.
//   tx_vld and ack_tx are never high in the same cycle.
// TESTING
//   1 type0 din=32'h49, tx_rdy=1 -> single byte 8'h49; ack_tx 1-cycle pulse the cycle after acceptance.
//   2 type1 din=32'h0000_1A2F -> bytes 30 30 30 30 31 41 32 46 20 in order; exactly one ack_tx.
//   3 Scenario 2 with tx_rdy random 30% duty -> identical byte sequence; tx_data stable while stalled; no drop or duplicate.
//   4 req_tx held high 3 cycles after ack -> no new tx_vld; req low 1 cycle then high with din=8'h3A -> one byte 3A.
//   5 rst pulsed after 3 of 9 bytes -> tx_vld/ack_tx/busy=0 immediately; after release, IDLE; no ack for the aborted word.
//   6 UPPER_CASE=0, din changes to 0 after acceptance of 32'hDEADBEEF -> bytes 64 65 61 64 62 65 65 66 20.

Source files
------------

// File: rtl/dcp_tx_printer_if.sv
// dcp_tx_printer_if: request/ack port from the command handlers plus the valid/ready byte stream to the UART.
interface dcp_tx_printer_if;
    logic        req_tx;
    logic        type_tx;
    logic [31:0] din_tx;
    logic        ack_tx;
    logic [7:0]  tx_data;
    logic        tx_vld;
    logic        tx_rdy;
    logic        busy;
    modport master (output req_tx, type_tx, din_tx, tx_rdy, input ack_tx, tx_data, tx_vld, busy);
    modport slave  (input req_tx, type_tx, din_tx, tx_rdy, output ack_tx, tx_data, tx_vld, busy);
endinterface

// File: rtl/dcp_tx_printer.sv
// dcp_tx_printer: formats a handler TX request as a raw byte or 8 ASCII hex digits and streams it over valid/ready.
module dcp_tx_printer #(
    parameter bit UPPER_CASE = 1'b1,
    parameter bit HEX_SPACE  = 1'b1
) (
    input logic             clk,
    input logic             rst,
    dcp_tx_printer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEND, ACK, WAITLO} state_t;
    state_t      state_q;
    logic [31:0] word_q;
    logic        type_q;
    logic [3:0]  idx_q, last_q;
    logic [7:0]  tx_data_q;
    logic        tx_vld_q, ack_q, busy_q;
    logic [3:0]  idx_d;
    assign idx_d = idx_q + 4'd1;
    function automatic logic [7:0] fmt_byte(input logic [31:0] w, input logic t, input logic [3:0] i);
        logic [3:0] n;
        n = 4'(w >> (5'd28 - {i[2:0], 2'b00}));
        if (!t) return w[7:0];
        if (i[3]) return 8'h20;
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : (UPPER_CASE ? 8'h37 : 8'h57) + {4'h0, n};
    endfunction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            word_q    <= '0;
            type_q    <= 1'b0;
            idx_q     <= '0;
            last_q    <= '0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.req_tx) begin
                    word_q    <= bus.din_tx;
                    type_q    <= bus.type_tx;
                    idx_q     <= '0;
                    last_q    <= bus.type_tx ? (HEX_SPACE ? 4'd8 : 4'd7) : 4'd0;
                    tx_data_q <= fmt_byte(bus.din_tx, bus.type_tx, 4'd0);
                    tx_vld_q  <= 1'b1;
                    busy_q    <= 1'b1;
                    state_q   <= SEND;
                end
                SEND: if (bus.tx_rdy) begin
                    if (idx_q == last_q) begin
                        tx_vld_q <= 1'b0;
                        ack_q    <= 1'b1;
                        state_q  <= ACK;
                    end else begin
                        idx_q     <= idx_d;
                        tx_data_q <= fmt_byte(word_q, type_q, idx_d);
                    end
                end
                ACK: begin
                    ack_q   <= 1'b0;
                    state_q <= WAITLO;
                end
                // the handler's req stays high until it sees ack; wait for it to drop
                WAITLO: if (!bus.req_tx) begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.tx_data = tx_data_q;
    assign bus.tx_vld  = tx_vld_q;
    assign bus.ack_tx  = ack_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_dcp_tx_printer.sv
// tb_dcp_tx_printer: scoreboard bench; stimulus pushes expected bytes, a negedge monitor pops and compares.
module tb_dcp_tx_printer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    dcp_tx_printer_if ia ();
    dcp_tx_printer_if ib ();
    dcp_tx_printer #(.UPPER_CASE(1'b1), .HEX_SPACE(1'b1)) u_a (.clk(clk), .rst(rst), .bus(ia.slave));
    dcp_tx_printer #(.UPPER_CASE(1'b0), .HEX_SPACE(1'b1)) u_b (.clk(clk), .rst(rst), .bus(ib.slave));
    logic        req [2];
    logic        typ [2];
    logic [31:0] din [2];
    logic        rdy [2];
    logic [1:0]  vld, ack, bsy;
    logic [7:0]  dat [2];
    assign ia.req_tx = req[0];
    assign ia.type_tx = typ[0];
    assign ia.din_tx = din[0];
    assign ia.tx_rdy = rdy[0];
    assign ib.req_tx = req[1];
    assign ib.type_tx = typ[1];
    assign ib.din_tx = din[1];
    assign ib.tx_rdy = rdy[1];
    assign vld = {ib.tx_vld, ia.tx_vld};
    assign ack = {ib.ack_tx, ia.ack_tx};
    assign bsy = {ib.busy, ia.busy};
    assign dat[0] = ia.tx_data;
    assign dat[1] = ib.tx_data;
    int checks = 0;
    int failures = 0;
    int ackcnt [2] = '{0, 0};
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic       held [2] = '{1'b0, 1'b0};
    logic [7:0] held_d [2];
    logic       ack_prev [2] = '{1'b0, 1'b0};
    logic       rnd = 1'b0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic push_bytes(input int u, input int n, input logic [71:0] v);
        for (int i = 0; i < n; i++) begin
            if (u == 0) q0.push_back(v[71-8*i -: 8]);
            else q1.push_back(v[71-8*i -: 8]);
        end
    endtask
    always @(negedge clk) begin
        if (!rst) begin
            for (int u = 0; u < 2; u++) begin
                check("vld_and_ack", {31'b0, vld[u] & ack[u]}, 32'd0);
                check("ack_twice", {31'b0, ack[u] & ack_prev[u]}, 32'd0);
                if (held[u] && vld[u]) check("stall_stable", {24'b0, dat[u]}, {24'b0, held_d[u]});
                if (vld[u] && rdy[u]) begin
                    logic [7:0] e;
                    logic       empty;
                    empty = (u == 0) ? (q0.size() == 0) : (q1.size() == 0);
                    if (empty) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_byte dut=%0d actual=%0h required=none", u, dat[u]);
                    end else begin
                        if (u == 0) e = q0.pop_front();
                        else e = q1.pop_front();
                        check(u == 0 ? "byte_a" : "byte_b", {24'b0, dat[u]}, {24'b0, e});
                    end
                end
                held[u] = vld[u] & ~rdy[u];
                held_d[u] = dat[u];
                ack_prev[u] = ack[u];
                if (ack[u]) ackcnt[u]++;
            end
        end
    end
    always @(posedge clk) begin
        #1;
        if (rnd) rdy[0] = ($urandom_range(9) < 3);
    end
    task automatic run_req(input int u, input bit t, input logic [31:0] d, input int hold, output int n);
        int a0;
        int k;
        a0 = ackcnt[u];
        req[u] = 1'b1;
        typ[u] = t;
        din[u] = d;
        @(posedge clk);
        #1;
        n = 1;
        din[u] = 32'h0;
        typ[u] = ~t;
        while (!ack[u] && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ack[u]) check("ack_timeout", 32'd0, 32'd1);
        repeat (hold) begin
            @(posedge clk);
            #1;
            check("hold_no_vld", {31'b0, vld[u]}, 32'd0);
        end
        req[u] = 1'b0;
        k = 0;
        while (bsy[u] && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("back_to_idle", {31'b0, bsy[u]}, 32'd0);
        @(negedge clk);
        #1;
        check("ack_count", 32'(ackcnt[u] - a0), 32'd1);
    endtask
    initial begin
        int n;
        int k;
        int a0;
        for (int u = 0; u < 2; u++) begin
            req[u] = 1'b0;
            typ[u] = 1'b0;
            din[u] = 32'h0;
            rdy[u] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check("rst_vld", {31'b0, vld[u]}, 32'd0);
            check("rst_ack", {31'b0, ack[u]}, 32'd0);
            check("rst_busy", {31'b0, bsy[u]}, 32'd0);
            check("rst_data", {24'b0, dat[u]}, 32'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_bytes(0, 1, 72'h49 << 64);
        run_req(0, 1'b0, 32'h49, 0, n);
        check("lat_type0", 32'(n), 32'd2);
        push_bytes(0, 1, 72'h80 << 64);
        run_req(0, 1'b0, 32'hFFFF_FF80, 0, n);
        push_bytes(0, 9, 72'h30_30_30_30_31_41_32_46_20);
        run_req(0, 1'b1, 32'h0000_1A2F, 0, n);
        check("lat_type1", 32'(n), 32'd10);
        rnd = 1'b1;
        push_bytes(0, 9, 72'h30_30_30_30_31_41_32_46_20);
        run_req(0, 1'b1, 32'h0000_1A2F, 0, n);
        rnd = 1'b0;
        rdy[0] = 1'b1;
        push_bytes(0, 1, 72'h55 << 64);
        run_req(0, 1'b0, 32'h55, 3, n);
        push_bytes(0, 1, 72'h3A << 64);
        run_req(0, 1'b0, 32'h3A, 0, n);
        push_bytes(1, 9, 72'h64_65_61_64_62_65_65_66_20);
        run_req(1, 1'b1, 32'hDEAD_BEEF, 0, n);
        push_bytes(1, 9, 72'h30_30_30_30_31_61_32_66_20);
        run_req(1, 1'b1, 32'h0000_1A2F, 0, n);
        push_bytes(0, 9, 72'h39_41_46_30_30_30_30_30_20);
        run_req(0, 1'b1, 32'h9AF0_0000, 0, n);
        push_bytes(0, 9, 72'h30_30_30_30_31_41_32_46_20);
        a0 = ackcnt[0];
        req[0] = 1'b1;
        typ[0] = 1'b1;
        din[0] = 32'h0000_1A2F;
        k = 0;
        while (q0.size() > 6 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("abort_reach", 32'(q0.size()), 32'd6);
        #2;
        rst = 1'b1;
        req[0] = 1'b0;
        #1;
        check("abort_vld", {31'b0, vld[0]}, 32'd0);
        check("abort_ack", {31'b0, ack[0]}, 32'd0);
        check("abort_busy", {31'b0, bsy[0]}, 32'd0);
        q0.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("abort_idle", {31'b0, bsy[0]}, 32'd0);
        check("abort_no_ack", 32'(ackcnt[0] - a0), 32'd0);
        push_bytes(0, 1, 72'h7E << 64);
        run_req(0, 1'b0, 32'h7E, 0, n);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
